// File: rtl/hcc_sync_fifo_ovfmode.sv
// Single-clock show-ahead FIFO for hit/event buffering with a selectable
// overflow policy (drop-oldest / reject-newest), synchronous flush,
// almost-full/almost-empty thresholds, sticky error flags and a saturating
// drop counter for slow-control monitoring.
module hcc_sync_fifo_ovfmode #(
   parameter int WORDWIDTH   = 8,
   parameter int logDEPTH    = 3,
   parameter int almostFULL  = 1,
   parameter int almostEMPTY = 1,
   parameter int CNTWIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic [WORDWIDTH-1:0]  data_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic                  ovfMode_i,
   input  logic                  flush_i,
   input  logic                  clrErr_i,
   output logic [WORDWIDTH-1:0]  data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almostFull_o,
   output logic                  almostEmpty_o,
   output logic [logDEPTH:0]     occupancy_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   output logic [CNTWIDTH-1:0]   dropCount_o
);

   localparam int MAX = 2 ** logDEPTH;
   localparam logic [logDEPTH:0] MAX_OCC  = (logDEPTH + 1)'(MAX);
   localparam logic [logDEPTH:0] AF_LEVEL = (logDEPTH + 1)'(MAX - almostFULL);
   localparam logic [logDEPTH:0] AE_LEVEL = (logDEPTH + 1)'(almostEMPTY);
   localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

   logic [WORDWIDTH-1:0] mem [MAX];
   logic [logDEPTH-1:0]  w_ptr;
   logic [logDEPTH-1:0]  r_ptr;
   logic [logDEPTH:0]    occ;

   logic is_empty;
   logic is_full;
   logic ovf_evt;
   logic unf_evt;
   logic do_write;
   logic do_pop;

   assign is_empty = (occ == '0);
   assign is_full  = (occ == MAX_OCC);

   // A write-without-read on a full FIFO is an overflow in either mode;
   // in drop-oldest mode it still writes and advances the read side.
   assign ovf_evt  = we_i & ~re_i & is_full;
   assign unf_evt  = re_i & is_empty;
   assign do_write = we_i & ~(ovf_evt & ovfMode_i);
   assign do_pop   = (re_i & ~is_empty) | (ovf_evt & ~ovfMode_i);

   // Pointer and occupancy tracking; flush beats any request in the same cycle.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         w_ptr <= '0;
         r_ptr <= '0;
         occ   <= '0;
      end else if (flush_i) begin
         w_ptr <= '0;
         r_ptr <= '0;
         occ   <= '0;
      end else begin
         if (do_write) w_ptr <= w_ptr + 1'b1;
         if (do_pop)   r_ptr <= r_ptr + 1'b1;
         case ({do_write, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage array, intentionally left unreset.
   always_ff @(posedge clk) begin
      if (rstb && !flush_i && do_write) begin
         mem[w_ptr] <= data_i;
      end
   end

   // Sticky error flags and saturating drop counter; a fresh event in the
   // same cycle as a clear is kept rather than lost.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
         dropCount_o <= '0;
      end else begin
         logic ovf_now;
         logic unf_now;
         ovf_now = ovf_evt & ~flush_i;
         unf_now = unf_evt & ~flush_i;
         if (clrErr_i) begin
            overflow_o  <= ovf_now;
            underflow_o <= unf_now;
            dropCount_o <= ovf_now ? CNTWIDTH'(1) : '0;
         end else begin
            if (ovf_now) overflow_o  <= 1'b1;
            if (unf_now) underflow_o <= 1'b1;
            if (ovf_now && dropCount_o != CNT_MAX) dropCount_o <= dropCount_o + 1'b1;
         end
      end
   end

   // Show-ahead head word and status decode from registered occupancy.
   always_comb begin
      data_o        = is_empty ? '0 : mem[r_ptr];
      empty_o       = is_empty;
      full_o        = is_full;
      almostFull_o  = (occ >= AF_LEVEL);
      almostEmpty_o = (occ <= AE_LEVEL);
      occupancy_o   = occ;
   end

endmodule
